// File: rtl/hvtx_pkg.sv
// Shared video types for the hvtx sync / pattern / modulator blocks.
package hvtx_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  localparam rgb_t RGB_BLACK = 24'h00_0000;

endpackage

// File: rtl/hvtx_box_if.sv
// Raster-in / video-out bundle between the raster stage, the box source and the modulator.
interface hvtx_box_if
  import hvtx_pkg::*;
#(
  parameter int WID = 12
);
  logic [WID-1:0] x;
  logic [WID-1:0] y;
  logic           hs;
  logic           vs;
  logic           de;
  logic           en;
  rgb_t           video;
  logic           o_hs;
  logic           o_vs;
  logic           o_de;
  logic [WID-1:0] box_x;
  logic [WID-1:0] box_y;

  // Raster side: drives position/strobes, consumes video.
  modport master (
    output x, y, hs, vs, de, en,
    input  video, o_hs, o_vs, o_de, box_x, box_y
  );

  // Pattern side: consumes position/strobes, drives video.
  modport slave (
    input  x, y, hs, vs, de, en,
    output video, o_hs, o_vs, o_de, box_x, box_y
  );
endinterface

// File: rtl/hvtx_box_axis.sv
// One bouncing axis: position register plus direction, moved on a step strobe.
module hvtx_box_axis
  import hvtx_pkg::*;
#(
  parameter int WID = 12
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [WID-1:0] i_max,
  input  logic [WID-1:0] i_step,
  input  logic           i_step_stb,
  output logic [WID-1:0] o_pos,
  output dir_e           o_dir
);

  logic [WID-1:0] pos_q, pos_d;
  dir_e           dir_q, dir_d;
  logic [WID:0]   sum;

  // Next position: clamp to the edge and turn around instead of overshooting.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    sum   = {1'b0, pos_q} + {1'b0, i_step};
    if (i_step_stb) begin
      if (dir_q == DIR_INC) begin
        if (sum >= {1'b0, i_max}) begin
          pos_d = i_max;
          dir_d = DIR_DEC;
        end else begin
          pos_d = sum[WID-1:0];
        end
      end else begin
        if (pos_q <= i_step) begin
          pos_d = '0;
          dir_d = DIR_INC;
        end else begin
          // pos_q > i_step here, so the subtraction cannot wrap
          pos_d = pos_q - i_step;
        end
      end
    end
  end

  // Position/direction state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pos_q <= '0;
      dir_q <= DIR_INC;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign o_pos = pos_q;
  assign o_dir = dir_q;

endmodule

// File: rtl/hvtx_box.sv
// Bouncing-square test pattern: frame tick/divider, two axes, 2-stage draw pipeline.
module hvtx_box
  import hvtx_pkg::*;
#(
  parameter int   WID             = 12,
  parameter int   ACTIVE_WIDTH    = 1920,
  parameter int   ACTIVE_HEIGHT   = 1080,
  parameter int   BOX_SIZE        = 10,
  parameter int   STEP            = 10,
  parameter int   FRAMES_PER_STEP = 1,
  parameter rgb_t COLOR           = 24'hff00a8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [WID-1:0] i_x,
  input  logic [WID-1:0] i_y,
  input  logic           i_hs,
  input  logic           i_vs,
  input  logic           i_de,
  input  logic           i_en,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_de,
  output rgb_t           o_video,
  output logic [WID-1:0] o_box_x,
  output logic [WID-1:0] o_box_y
);

  localparam logic [WID-1:0] MAX_X   = WID'(ACTIVE_WIDTH - BOX_SIZE);
  localparam logic [WID-1:0] MAX_Y   = WID'(ACTIVE_HEIGHT - BOX_SIZE);
  localparam logic [WID-1:0] STEP_W  = WID'(STEP);
  localparam logic [WID:0]   BOX_W1  = (WID+1)'(BOX_SIZE);
  localparam int             DIV_W   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);

  logic             tick;
  logic             step_stb;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WID-1:0]   box_x, box_y;

  // sync_q[s] = {hs,vs,de} after s register stages
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [3:0]       hit_q, hit_d;
  rgb_t             video_q, video_d;

  // First blanking line, first pixel: safe point to move the box.
  assign tick = (i_x == '0) && (i_y == WID'(ACTIVE_HEIGHT));

  // Frame divider: counts enabled ticks, steps on the last count and wraps.
  always_comb begin
    div_d    = div_q;
    step_stb = 1'b0;
    if (tick && i_en) begin
      if (div_q == DIV_LAST) begin
        div_d    = '0;
        step_stb = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Divider state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) div_q <= '0;
    else          div_q <= div_d;
  end

  hvtx_box_axis #(.WID(WID)) u_axis_x (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_max      (MAX_X),
    .i_step     (STEP_W),
    .i_step_stb (step_stb),
    .o_pos      (box_x),
    .o_dir      ()
  );

  hvtx_box_axis #(.WID(WID)) u_axis_y (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_max      (MAX_Y),
    .i_step     (STEP_W),
    .i_step_stb (step_stb),
    .o_pos      (box_y),
    .o_dir      ()
  );

  // Stage 1: box-edge compares against the current position, syncs delayed once.
  always_comb begin
    hit_d[0] = i_x >= box_x;
    hit_d[1] = {1'b0, i_x} < ({1'b0, box_x} + BOX_W1);
    hit_d[2] = i_y >= box_y;
    hit_d[3] = {1'b0, i_y} < ({1'b0, box_y} + BOX_W1);
    sync1_d  = {i_hs, i_vs, i_de};
  end

  // Stage 2: colour select, gated by the delayed data-enable.
  always_comb begin
    video_d = (&hit_q && sync1_q[0]) ? COLOR : RGB_BLACK;
    sync2_d = sync1_q;
  end

  // Draw pipeline registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      video_q <= RGB_BLACK;
    end else begin
      hit_q   <= hit_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      video_q <= video_d;
    end
  end

  assign o_hs    = sync2_q[2];
  assign o_vs    = sync2_q[1];
  assign o_de    = sync2_q[0];
  assign o_video = video_q;
  assign o_box_x = box_x;
  assign o_box_y = box_y;

endmodule

// File: tb/tb_hvtx_box.sv
// Directed bench: reset, draw bounds, stepping, divider, freeze, bounce and corner.
module tb_hvtx_box;
  import hvtx_pkg::*;

  localparam rgb_t COL = 24'hff00a8;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  hvtx_box_if #(.WID(12)) bus ();

  // FRAMES_PER_STEP = 3 instance
  logic        h3, v3, d3;
  rgb_t        vid3;
  logic [11:0] bx3, by3;
  // small square raster instance for a simultaneous corner hit
  logic        hc, vc, dc;
  rgb_t        vidc;
  logic [11:0] bxc, byc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hvtx_box dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_x(bus.x), .i_y(bus.y), .i_hs(bus.hs), .i_vs(bus.vs), .i_de(bus.de), .i_en(bus.en),
    .o_hs(bus.o_hs), .o_vs(bus.o_vs), .o_de(bus.o_de), .o_video(bus.video),
    .o_box_x(bus.box_x), .o_box_y(bus.box_y)
  );

  hvtx_box #(.FRAMES_PER_STEP(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_x(bus.x), .i_y(bus.y), .i_hs(bus.hs), .i_vs(bus.vs), .i_de(bus.de), .i_en(bus.en),
    .o_hs(h3), .o_vs(v3), .o_de(d3), .o_video(vid3),
    .o_box_x(bx3), .o_box_y(by3)
  );

  hvtx_box #(.ACTIVE_WIDTH(100), .ACTIVE_HEIGHT(100)) dutc (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_x(bus.x), .i_y(bus.y), .i_hs(bus.hs), .i_vs(bus.vs), .i_de(bus.de), .i_en(bus.en),
    .o_hs(hc), .o_vs(vc), .o_de(dc), .o_video(vidc),
    .o_box_x(bxc), .o_box_y(byc)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // One-cycle frame tick at line ty, then park the raster off the tick.
  task automatic do_tick(input int ty);
    bus.x = 12'd0;
    bus.y = 12'(ty);
    step_clk();
    bus.x = 12'd1;
    bus.y = 12'd0;
  endtask

  // Drive a pixel and return video 2 cycles later.
  task automatic pix(input int px, input int py, input logic de, output rgb_t v);
    bus.x  = 12'(px);
    bus.y  = 12'(py);
    bus.de = de;
    step_clk();
    step_clk();
    v = bus.video;
  endtask

  task automatic test_reset();
    rgb_t v;
    rst_n = 1'b0;
    bus.x = '0; bus.y = '0; bus.hs = 0; bus.vs = 0; bus.de = 0; bus.en = 1;
    for (int i = 0; i < 4; i++) begin
      bus.hs = ~bus.hs; bus.vs = ~bus.vs; bus.de = ~bus.de;
      step_clk();
    end
    n_checks++;
    if ({bus.o_hs, bus.o_vs, bus.o_de} !== 3'b000 || bus.video !== 24'h0)
      $display("FAIL reset_out: got hs/vs/de=%b%b%b video=%h want 000/000000",
               bus.o_hs, bus.o_vs, bus.o_de, bus.video);
    else n_pass++;
    n_checks++;
    if (bus.box_x !== 12'd0 || bus.box_y !== 12'd0)
      $display("FAIL reset_box: got (%0d,%0d) want (0,0)", bus.box_x, bus.box_y);
    else n_pass++;
    // release, fill pipeline with a lit pixel, then reset between edges
    rst_n = 1'b1;
    bus.hs = 1; bus.vs = 1;
    pix(0, 0, 1'b1, v);
    n_checks++;
    if (v !== COL || {bus.o_hs, bus.o_vs, bus.o_de} !== 3'b111)
      $display("FAIL reset_prefill: got video=%h syncs=%b%b%b want %h/111",
               v, bus.o_hs, bus.o_vs, bus.o_de, COL);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.video !== 24'h0 || {bus.o_hs, bus.o_vs, bus.o_de} !== 3'b000)
      $display("FAIL reset_async: got video=%h syncs=%b%b%b want 000000/000",
               bus.video, bus.o_hs, bus.o_vs, bus.o_de);
    else n_pass++;
    bus.hs = 0; bus.vs = 0; bus.de = 0;
    step_clk();
    rst_n = 1'b1;
    step_clk();
  endtask

  task automatic test_draw();
    rgb_t v;
    int   px[5]   = '{0, 9, 10, 0, 0};
    int   py[5]   = '{0, 9, 0, 10, 0};
    logic pde[5]  = '{1, 1, 1, 1, 0};
    rgb_t exp_v[5] = '{COL, COL, 24'h0, 24'h0, 24'h0};
    for (int i = 0; i < 5; i++) begin
      pix(px[i], py[i], pde[i], v);
      n_checks++;
      if (v !== exp_v[i])
        $display("FAIL draw_%0d: (%0d,%0d,de=%0d) got %h want %h", i, px[i], py[i], pde[i], v, exp_v[i]);
      else n_pass++;
    end
    // sync latency: not yet after 1 cycle, present after 2
    bus.hs = 0; bus.vs = 0;
    step_clk(); step_clk();
    bus.hs = 1; bus.vs = 1;
    step_clk();
    n_checks++;
    if (bus.o_hs !== 1'b0 || bus.o_vs !== 1'b0)
      $display("FAIL sync_lat1: got hs=%b vs=%b want 0 0", bus.o_hs, bus.o_vs);
    else n_pass++;
    step_clk();
    n_checks++;
    if (bus.o_hs !== 1'b1 || bus.o_vs !== 1'b1)
      $display("FAIL sync_lat2: got hs=%b vs=%b want 1 1", bus.o_hs, bus.o_vs);
    else n_pass++;
    bus.hs = 0; bus.vs = 0;
  endtask

  task automatic test_step();
    rgb_t v;
    // x != 0 on the blanking line is not a tick
    bus.x = 12'd1; bus.y = 12'd1080;
    step_clk();
    bus.y = 12'd0;
    n_checks++;
    if (bus.box_x !== 12'd0 || bus.box_y !== 12'd0)
      $display("FAIL step_notick: got (%0d,%0d) want (0,0)", bus.box_x, bus.box_y);
    else n_pass++;
    do_tick(1080);
    n_checks++;
    if (bus.box_x !== 12'd10 || bus.box_y !== 12'd10)
      $display("FAIL step_1: got (%0d,%0d) want (10,10)", bus.box_x, bus.box_y);
    else n_pass++;
    n_checks++;
    if (bx3 !== 12'd0 || by3 !== 12'd0)
      $display("FAIL div3_t1: got (%0d,%0d) want (0,0)", bx3, by3);
    else n_pass++;
    pix(19, 19, 1'b1, v);
    n_checks++;
    if (v !== COL) $display("FAIL draw_moved_in: got %h want %h", v, COL);
    else n_pass++;
    pix(9, 9, 1'b1, v);
    n_checks++;
    if (v !== 24'h0) $display("FAIL draw_moved_out: got %h want 000000", v);
    else n_pass++;
    do_tick(1080);
    n_checks++;
    if (bx3 !== 12'd0 || by3 !== 12'd0)
      $display("FAIL div3_t2: got (%0d,%0d) want (0,0)", bx3, by3);
    else n_pass++;
    do_tick(1080);
    n_checks++;
    if (bx3 !== 12'd10 || by3 !== 12'd10)
      $display("FAIL div3_t3: got (%0d,%0d) want (10,10)", bx3, by3);
    else n_pass++;
    n_checks++;
    if (bus.box_x !== 12'd30 || bus.box_y !== 12'd30)
      $display("FAIL step_3: got (%0d,%0d) want (30,30)", bus.box_x, bus.box_y);
    else n_pass++;
  endtask

  task automatic test_freeze();
    rgb_t v;
    do_tick(1080);  // main (40,40), dut3 divider 1
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) do_tick(1080);
    n_checks++;
    if (bus.box_x !== 12'd40 || bus.box_y !== 12'd40 || bx3 !== 12'd10)
      $display("FAIL freeze_hold: got main (%0d,%0d) div3 x=%0d want (40,40) 10",
               bus.box_x, bus.box_y, bx3);
    else n_pass++;
    pix(40, 40, 1'b1, v);
    n_checks++;
    if (v !== COL) $display("FAIL freeze_draw_in: got %h want %h", v, COL);
    else n_pass++;
    pix(39, 40, 1'b1, v);
    n_checks++;
    if (v !== 24'h0) $display("FAIL freeze_draw_out: got %h want 000000", v);
    else n_pass++;
    bus.en = 1'b1;
    do_tick(1080);  // main (50,50), dut3 divider 2, no move
    n_checks++;
    if (bx3 !== 12'd10 || bus.box_x !== 12'd50)
      $display("FAIL resume_1: got div3 x=%0d main x=%0d want 10 50", bx3, bus.box_x);
    else n_pass++;
    do_tick(1080);  // main (60,60), dut3 steps
    n_checks++;
    if (bx3 !== 12'd20 || by3 !== 12'd20 || bus.box_x !== 12'd60)
      $display("FAIL resume_2: got div3 (%0d,%0d) main x=%0d want (20,20) 60", bx3, by3, bus.box_x);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int k = 6;  // main steps taken so far
    while (k < 190) begin do_tick(1080); k++; end
    n_checks++;
    if (bus.box_x !== 12'd1900 || bus.box_y !== 12'd240)
      $display("FAIL bounce_190: got (%0d,%0d) want (1900,240)", bus.box_x, bus.box_y);
    else n_pass++;
    do_tick(1080); k++;
    n_checks++;
    if (bus.box_x !== 12'd1910 || bus.box_y !== 12'd230)
      $display("FAIL bounce_max: got (%0d,%0d) want (1910,230)", bus.box_x, bus.box_y);
    else n_pass++;
    do_tick(1080); k++;
    n_checks++;
    if (bus.box_x !== 12'd1900 || bus.box_y !== 12'd220)
      $display("FAIL bounce_back: got (%0d,%0d) want (1900,220)", bus.box_x, bus.box_y);
    else n_pass++;
    while (k < 214) begin do_tick(1080); k++; end
    n_checks++;
    if (bus.box_x !== 12'd1680 || bus.box_y !== 12'd0)
      $display("FAIL bounce_ymin: got (%0d,%0d) want (1680,0)", bus.box_x, bus.box_y);
    else n_pass++;
    do_tick(1080); k++;
    n_checks++;
    if (bus.box_y !== 12'd10)
      $display("FAIL bounce_yup: got y=%0d want 10", bus.box_y);
    else n_pass++;
    while (k < 381) begin do_tick(1080); k++; end
    n_checks++;
    if (bus.box_x !== 12'd10) $display("FAIL bounce_x10: got x=%0d want 10", bus.box_x);
    else n_pass++;
    do_tick(1080); k++;
    n_checks++;
    if (bus.box_x !== 12'd0) $display("FAIL bounce_xmin: got x=%0d want 0", bus.box_x);
    else n_pass++;
    do_tick(1080); k++;
    n_checks++;
    if (bus.box_x !== 12'd10) $display("FAIL bounce_xup: got x=%0d want 10", bus.box_x);
    else n_pass++;
  endtask

  task automatic test_corner();
    for (int i = 0; i < 8; i++) do_tick(100);
    n_checks++;
    if (bxc !== 12'd80 || byc !== 12'd80)
      $display("FAIL corner_pre: got (%0d,%0d) want (80,80)", bxc, byc);
    else n_pass++;
    do_tick(100);
    n_checks++;
    if (bxc !== 12'd90 || byc !== 12'd90)
      $display("FAIL corner_hit: got (%0d,%0d) want (90,90)", bxc, byc);
    else n_pass++;
    do_tick(100);
    n_checks++;
    if (bxc !== 12'd80 || byc !== 12'd80)
      $display("FAIL corner_back: got (%0d,%0d) want (80,80)", bxc, byc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_draw();
    test_step();
    test_freeze();
    test_bounce();
    test_corner();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
